// File: rtl/pit_program_ctrl.sv
// pit_program_ctrl: sequences one command into i8253 bus writes (mode word, then LSB and/or MSB
// count) with fixed setup/strobe/hold/recovery timing. Optional build macro PC_INIT_EN runs two
// built-in commands after reset (counter 0 mode 3 /65536, counter 1 mode 2 /18) before REQ.
module pit_program_ctrl #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned WR_CYC    = 4,
    parameter int unsigned HOLD_CYC  = 1,
    parameter int unsigned GAP_CYC   = 8
) (
    input  logic        CLK,
    input  logic        RESET_,
    input  logic        REQ,
    input  logic [1:0]  CNT_SEL,
    input  logic [1:0]  RW,
    input  logic [2:0]  MODE,
    input  logic        BCD,
    input  logic [15:0] COUNT,
    output logic        ACK,
    output logic        ERR,
    output logic        BUSY,
    output logic [1:0]  A,
    output logic        CS_,
    output logic        WR_,
    output logic        RD_,
    output logic [7:0]  D_OUT,
    output logic        D_OE
);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StGap} state_t;
    typedef enum logic [1:0] {PhMode, PhLsb, PhMsb} phase_t;

    state_t      r_state, w_state_nx;
    phase_t      r_phase, w_phase_nx, w_next_ph;
    logic [7:0]  r_cnt, w_cnt_nx;
    logic [1:0]  r_sel, w_sel_nx;
    logic [1:0]  r_rw, w_rw_nx;
    logic [2:0]  r_mode, w_mode_nx;
    logic        r_bcd, w_bcd_nx;
    logic [15:0] r_count, w_count_nx;
    logic        r_ack, w_ack_nx;
    logic        r_err, w_err_nx;
    logic        w_more;
    logic        w_blk;

`ifdef PC_INIT_EN
    logic        r_boot;
    logic [1:0]  r_init, w_init_nx;   // 0: none, 1: first built-in running, 2: second running
    logic        r_hold, w_hold_nx;   // blocks REQ in the first idle cycle after the built-ins
    assign w_blk = r_ack | r_err | r_hold;
`else
    assign w_blk = r_ack | r_err;
`endif

    // Decide whether another write follows the current phase, and which one.
    always_comb begin
        w_more    = 1'b0;
        w_next_ph = PhMode;
        case (r_phase)
            PhMode: begin
                if (r_rw[0]) begin
                    w_more    = 1'b1;
                    w_next_ph = PhLsb;
                end else if (r_rw[1]) begin
                    w_more    = 1'b1;
                    w_next_ph = PhMsb;
                end
            end
            PhLsb: begin
                if (r_rw[1]) begin
                    w_more    = 1'b1;
                    w_next_ph = PhMsb;
                end
            end
            default: ;
        endcase
    end

    // Next-state logic: command acceptance, timing counters and phase sequencing.
    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_cnt_nx   = r_cnt;
        w_sel_nx   = r_sel;
        w_rw_nx    = r_rw;
        w_mode_nx  = r_mode;
        w_bcd_nx   = r_bcd;
        w_count_nx = r_count;
        w_ack_nx   = 1'b0;
        w_err_nx   = 1'b0;
`ifdef PC_INIT_EN
        w_init_nx  = r_init;
        w_hold_nx  = 1'b0;
`endif
        case (r_state)
            StIdle: begin
`ifdef PC_INIT_EN
                if (r_boot) begin
                    w_sel_nx   = 2'd0;
                    w_rw_nx    = 2'd3;
                    w_mode_nx  = 3'd3;
                    w_bcd_nx   = 1'b0;
                    w_count_nx = 16'h0000;
                    w_init_nx  = 2'd1;
                    w_phase_nx = PhMode;
                    w_cnt_nx   = 8'(SETUP_CYC - 1);
                    w_state_nx = StSetup;
                end else
`endif
                if (REQ && !w_blk) begin
                    if (CNT_SEL == 2'd3) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_sel_nx   = CNT_SEL;
                        w_rw_nx    = RW;
                        w_mode_nx  = MODE;
                        w_bcd_nx   = BCD;
                        w_count_nx = COUNT;
                        w_phase_nx = PhMode;
                        w_cnt_nx   = 8'(SETUP_CYC - 1);
                        w_state_nx = StSetup;
                    end
                end
            end
            StSetup: begin
                if (r_cnt == 8'd0) begin
                    w_cnt_nx   = 8'(WR_CYC - 1);
                    w_state_nx = StStrobe;
                end else begin
                    w_cnt_nx = r_cnt - 8'd1;
                end
            end
            StStrobe: begin
                if (r_cnt == 8'd0) begin
                    w_cnt_nx   = 8'(HOLD_CYC - 1);
                    w_state_nx = StHold;
                end else begin
                    w_cnt_nx = r_cnt - 8'd1;
                end
            end
            StHold: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nx = r_cnt - 8'd1;
                end else if (w_more) begin
                    w_phase_nx = w_next_ph;
                    if (GAP_CYC > 0) begin
                        w_cnt_nx   = 8'(GAP_CYC - 1);
                        w_state_nx = StGap;
                    end else begin
                        w_cnt_nx   = 8'(SETUP_CYC - 1);
                        w_state_nx = StSetup;
                    end
`ifdef PC_INIT_EN
                end else if (r_init == 2'd1) begin
                    // Chain straight into the second built-in command.
                    w_sel_nx   = 2'd1;
                    w_rw_nx    = 2'd1;
                    w_mode_nx  = 3'd2;
                    w_bcd_nx   = 1'b0;
                    w_count_nx = 16'h0012;
                    w_init_nx  = 2'd2;
                    w_phase_nx = PhMode;
                    if (GAP_CYC > 0) begin
                        w_cnt_nx   = 8'(GAP_CYC - 1);
                        w_state_nx = StGap;
                    end else begin
                        w_cnt_nx   = 8'(SETUP_CYC - 1);
                        w_state_nx = StSetup;
                    end
                end else if (r_init == 2'd2) begin
                    w_init_nx  = 2'd0;
                    w_hold_nx  = 1'b1;
                    w_state_nx = StIdle;
`endif
                end else begin
                    w_ack_nx   = 1'b1;
                    w_state_nx = StIdle;
                end
            end
            StGap: begin
                if (r_cnt == 8'd0) begin
                    w_cnt_nx   = 8'(SETUP_CYC - 1);
                    w_state_nx = StSetup;
                end else begin
                    w_cnt_nx = r_cnt - 8'd1;
                end
            end
            default: w_state_nx = StIdle;
        endcase
    end

    // State and latched-command registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET_) begin
            r_state <= StIdle;
            r_phase <= PhMode;
            r_cnt   <= 8'd0;
            r_sel   <= 2'd0;
            r_rw    <= 2'd0;
            r_mode  <= 3'd0;
            r_bcd   <= 1'b0;
            r_count <= 16'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
`ifdef PC_INIT_EN
            r_boot  <= 1'b1;
            r_init  <= 2'd0;
            r_hold  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_phase <= w_phase_nx;
            r_cnt   <= w_cnt_nx;
            r_sel   <= w_sel_nx;
            r_rw    <= w_rw_nx;
            r_mode  <= w_mode_nx;
            r_bcd   <= w_bcd_nx;
            r_count <= w_count_nx;
            r_ack   <= w_ack_nx;
            r_err   <= w_err_nx;
`ifdef PC_INIT_EN
            r_boot  <= 1'b0;
            r_init  <= w_init_nx;
            r_hold  <= w_hold_nx;
`endif
        end
    end

    // Bus pin decode from the current state and write phase.
    always_comb begin
        CS_   = 1'b1;
        WR_   = 1'b1;
        RD_   = 1'b1;
        A     = 2'd0;
        D_OUT = 8'd0;
        D_OE  = 1'b0;
        if (r_state == StSetup || r_state == StStrobe || r_state == StHold) begin
            CS_  = 1'b0;
            D_OE = 1'b1;
            WR_  = (r_state != StStrobe);
            case (r_phase)
                PhLsb: begin
                    A     = r_sel;
                    D_OUT = r_count[7:0];
                end
                PhMsb: begin
                    A     = r_sel;
                    D_OUT = r_count[15:8];
                end
                default: begin
                    A     = 2'd3;
                    D_OUT = {r_sel, r_rw, r_mode, r_bcd};
                end
            endcase
        end
        ACK  = r_ack;
        ERR  = r_err;
        BUSY = (r_state != StIdle) || r_ack;
    end

endmodule

// File: tb/tb_pit_program_ctrl.sv
// Scoreboard bench for pit_program_ctrl: driver pushes expected writes/completions, a negedge
// monitor pops and compares bus writes, timing, ACK/ERR latency and BUSY span.
module tb_pit_program_ctrl;

    localparam int unsigned S = 2;
    localparam int unsigned W = 4;
    localparam int unsigned H = 1;
    localparam int unsigned G = 8;

    typedef struct packed {
        logic        is_err;
        logic [31:0] k;
        logic [31:0] lat;
    } end_t;

    logic        CLK = 1'b0;
    logic        RESET_;
    logic        REQ;
    logic [1:0]  CNT_SEL;
    logic [1:0]  RW;
    logic [2:0]  MODE;
    logic        BCD;
    logic [15:0] COUNT;
    logic        ACK, ERR, BUSY, CS_, WR_, RD_, D_OE;
    logic [1:0]  A;
    logic [7:0]  D_OUT;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned cyc    = 0;

    logic [9:0] exp_wr[$];
    end_t       exp_end[$];

    pit_program_ctrl dut (
        .CLK(CLK), .RESET_(RESET_), .REQ(REQ), .CNT_SEL(CNT_SEL), .RW(RW), .MODE(MODE),
        .BCD(BCD), .COUNT(COUNT), .ACK(ACK), .ERR(ERR), .BUSY(BUSY), .A(A), .CS_(CS_),
        .WR_(WR_), .RD_(RD_), .D_OUT(D_OUT), .D_OE(D_OE)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    // Reference model: list of writes and completion latency for one command.
    task automatic push_cmd(input logic [1:0] sel, input logic [1:0] rw, input logic [2:0] mode,
                            input logic bcd, input logic [15:0] count, input logic [31:0] k);
        end_t e;
        int unsigned n;
        e.k = k;
        if (sel == 2'd3) begin
            e.is_err = 1'b1;
            e.lat    = 1;
        end else begin
            exp_wr.push_back({2'd3, sel, rw, mode, bcd});
            n = 1;
            if (rw[0]) begin
                exp_wr.push_back({sel, count[7:0]});
                n++;
            end
            if (rw[1]) begin
                exp_wr.push_back({sel, count[15:8]});
                n++;
            end
            e.is_err = 1'b0;
            e.lat    = n * (S + W + H) + (n - 1) * G + 1;
        end
        exp_end.push_back(e);
    endtask

    // Issue a command and hold REQ until ACK/ERR; fields are scrambled while busy.
    task automatic run_cmd(input logic [1:0] sel, input logic [1:0] rw, input logic [2:0] mode,
                           input logic bcd, input logic [15:0] count);
        logic done;
        CNT_SEL = sel;
        RW      = rw;
        MODE    = mode;
        BCD     = bcd;
        COUNT   = count;
        REQ     = 1'b1;
        push_cmd(sel, rw, mode, bcd, count, cyc + 1);
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick(1);
            if (ACK || ERR) begin
                done = 1'b1;
            end else begin
                CNT_SEL = 2'($urandom);
                RW      = 2'($urandom);
                MODE    = 3'($urandom);
                BCD     = 1'($urandom);
                COUNT   = 16'($urandom);
            end
        end
        chk("cmd_completed", {31'd0, done}, 32'd1);
        REQ = 1'b0;
    endtask

    // Monitor: bus write timing/content and completion pulses.
    initial begin
        logic        prev_cs = 1'b1;
        logic        had_wr  = 1'b0;
        logic        stable  = 1'b1;
        logic [1:0]  cap_a   = 2'd0;
        logic [7:0]  cap_d   = 8'd0;
        int unsigned setup_n = 0, wr_n = 0, hold_n = 0, gap_n = 0, busy_run = 0;
        end_t        e;
        forever begin
            @(negedge CLK);
            if (!RESET_) begin
                prev_cs  = 1'b1;
                had_wr   = 1'b0;
                busy_run = 0;
            end else begin
                if (BUSY) busy_run++;
                else busy_run = 0;
                if (!CS_) begin
                    if (prev_cs) begin
                        if (had_wr) chk("gap_cycles", gap_n, G);
                        setup_n = 0;
                        wr_n    = 0;
                        hold_n  = 0;
                        cap_a   = A;
                        cap_d   = D_OUT;
                        stable  = 1'b1;
                    end
                    if (A !== cap_a || D_OUT !== cap_d || D_OE !== 1'b1) stable = 1'b0;
                    if (!WR_) wr_n++;
                    else if (wr_n == 0) setup_n++;
                    else hold_n++;
                end else begin
                    if (!prev_cs) begin
                        chk("setup_cycles", setup_n, S);
                        chk("strobe_cycles", wr_n, W);
                        chk("hold_cycles", hold_n, H);
                        chk("bus_stable", {31'd0, stable}, 32'd1);
                        if (exp_wr.size() == 0) begin
                            chk("unexpected_write", {22'd0, cap_a, cap_d}, 32'h3ff);
                        end else begin
                            chk("write_addr_data", {22'd0, cap_a, cap_d},
                                {22'd0, exp_wr.pop_front()});
                        end
                        had_wr = 1'b1;
                        gap_n  = 1;
                    end else begin
                        gap_n++;
                    end
                end
                prev_cs = CS_;
                if (ACK || ERR) begin
                    if (exp_end.size() == 0) begin
                        chk("unexpected_ack_err", {30'd0, ACK, ERR}, 32'd0);
                    end else begin
                        e = exp_end.pop_front();
                        chk("end_kind", {30'd0, ACK, ERR}, e.is_err ? 32'd1 : 32'd2);
                        chk("end_cycle", cyc - e.k + 1, e.lat);
                        if (e.is_err) chk("err_idle_bus", {30'd0, BUSY, CS_}, 32'd1);
                        else chk("busy_span", busy_run, e.lat);
                        chk("rd_high", {31'd0, RD_}, 32'd1);
                    end
                    had_wr = 1'b0;
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int falls;
        logic prev_wr;
        RESET_  = 1'b0;
        REQ     = 1'b0;
        CNT_SEL = 2'd0;
        RW      = 2'd0;
        MODE    = 3'd0;
        BCD     = 1'b0;
        COUNT   = 16'd0;
        tick(3);
        chk("rst_bus", {21'd0, CS_, WR_, RD_, A, D_OUT, D_OE}, {21'd0, 3'b111, 2'd0, 8'd0, 1'b0});
        chk("rst_ack_err_busy", {29'd0, ACK, ERR, BUSY}, 32'd0);
        RESET_ = 1'b1;
        tick(2);

        run_cmd(2'd0, 2'b01, 3'd0, 1'b0, 16'h0004);
        tick(1);
        run_cmd(2'd2, 2'b11, 3'd3, 1'b0, 16'h1234);
        tick(1);
        run_cmd(2'd1, 2'b00, 3'd0, 1'b0, 16'hFFFF);
        tick(1);
        run_cmd(2'd3, 2'b01, 3'd2, 1'b0, 16'h5555);
        tick(1);
        run_cmd(2'd1, 2'b10, 3'd7, 1'b1, 16'hA5C3);
        tick(1);
        for (int i = 0; i < 25; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 2'($urandom), 3'($urandom), 1'($urandom),
                    16'($urandom));
            tick($urandom_range(1, 3));
        end

        // Reset during the LSB strobe aborts the command without ACK.
        CNT_SEL = 2'd0;
        RW      = 2'b01;
        MODE    = 3'd0;
        BCD     = 1'b0;
        COUNT   = 16'h00AB;
        REQ     = 1'b1;
        exp_wr.push_back({2'd3, 8'h10});
        falls   = 0;
        prev_wr = 1'b1;
        for (int i = 0; i < 100 && falls < 2; i++) begin
            tick(1);
            if (!WR_ && prev_wr) falls++;
            prev_wr = WR_;
        end
        chk("reached_lsb_strobe", 32'(falls), 32'd2);
        RESET_ = 1'b0;
        REQ    = 1'b0;
        tick(1);
        chk("abort_bus", {29'd0, CS_, WR_, D_OE}, 32'b110);
        chk("abort_ack_busy", {30'd0, ACK, BUSY}, 32'd0);
        tick(2);
        RESET_ = 1'b1;
        chk("abort_flushed_writes", exp_wr.size(), 0);
        tick(30);

        run_cmd(2'd1, 2'b11, 3'd5, 1'b1, 16'hBEEF);
        tick(3);
        chk("writes_drained", exp_wr.size(), 0);
        chk("ends_drained", exp_end.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pit_program_ctrl.md
Name: pit_program_ctrl

Overview:
Bus-cycle sequencer that programs the i8253 timer from a simple request/acknowledge command port. It turns one command into an ordered series of 8253 writes on the A1/A0, CS_, WR_ and D pins: the mode word, then the LSB and/or MSB count. It guarantees the setup, strobe, hold and recovery timing between those writes. It sits between the system control logic and the i8253 instance, and it is the only master on the timer's write bus.

Parameters:
SETUP_CYC, 2, cycles with CS_ low and A/D valid before WR_ falls (min 1)
WR_CYC, 4, cycles WR_ is held low (min 1)
HOLD_CYC, 1, cycles CS_, A and D stay valid after WR_ rises (min 1)
GAP_CYC, 8, recovery cycles with CS_ high between writes of one command (min 0)

Ports:
CLK  in  1  system clock; all logic is on the rising edge
RESET_  in  1  synchronous, active-low reset
REQ  in  1  command request; held high with the fields stable until ACK
CNT_SEL  in  2  target counter 0..2; 3 is illegal
RW  in  2  8253 RW field: 00 latch, 01 LSB, 10 MSB, 11 LSB then MSB
MODE  in  3  8253 mode field
BCD  in  1  BCD/binary select
COUNT  in  16  count value; LSB = COUNT[7:0], MSB = COUNT[15:8]
ACK  out  1  one-cycle pulse when the command has completed
ERR  out  1  one-cycle pulse when a command is rejected
BUSY  out  1  high while a sequence is in progress
A  out  2  drives {A1,A0}
CS_  out  1  i8253 chip select, active low
WR_  out  1  i8253 write strobe, active low
RD_  out  1  i8253 read strobe; constant 1
D_OUT  out  8  write data
D_OE  out  1  data bus output enable

Behaviour:
- Reset values: CS_=1, WR_=1, RD_=1, A=0, D_OUT=0, D_OE=0, ACK=0, ERR=0, BUSY=0; state IDLE.
- Reset asserted mid-sequence aborts the sequence at the next edge. All outputs return to their reset values and no ACK is issued.
- States: IDLE, SETUP, STROBE, HOLD, GAP.
- Write phases are MODEW, LSBW and MSBW, issued in that order.
  - MODEW is always issued.
  - LSBW is issued when RW[0]=1.
  - MSBW is issued when RW[1]=1.
- Acceptance: REQ is sampled in IDLE at edge k.
  - If CNT_SEL=3: ERR=1 for cycle k+1, no bus activity, stay in IDLE.
  - Otherwise: latch the fields, BUSY=1 from cycle k+1 until the ACK cycle inclusive.
- Data per phase:
  - Mode word = {CNT_SEL, RW, MODE, BCD}, written with A=3.
  - LSB and MSB writes use A=CNT_SEL.
- Timing of one write (S=SETUP_CYC, W=WR_CYC, H=HOLD_CYC), with cycle 1 being the first cycle of the write:
  - CS_=0 and D_OE=1 with A and D_OUT valid in cycles 1..S+W+H.
  - WR_=0 in cycles S+1..S+W.
- Between writes of the same command: GAP_CYC cycles with CS_=1, WR_=1, D_OE=0. No gap follows the last write.
- ACK=1 for the one cycle after the last HOLD cycle; the state returns to IDLE in that same cycle.
  - The next REQ is sampled no earlier than the cycle after ACK.
  - The requester drops REQ on seeing ACK. A REQ still high in the cycle after ACK is treated as a new command.
- Cycle counts with defaults:
  - RW=00: ACK in cycle 8.
  - RW=01 or RW=10: ACK in cycle 23.
  - RW=11: ACK in cycle 38.
- Field changes while BUSY have no effect.
- MODE values 6 and 7 pass through unchanged.
- Timing counters are 8 bits wide and load (param-1).

Optional Feature:
Macro PC_INIT_EN.
- Defined: after reset deassertion, the controller runs two built-in commands before it accepts REQ:
  - counter 0, mode word 0x36, LSB 0x00, MSB 0x00 (mode 3, divide by 65536);
  - then counter 1, mode word 0x54, LSB 0x12 (mode 2, refresh divisor 18).
  - Both use the normal timing, with GAP_CYC cycles between them.
  - BUSY=1 throughout, and no ACK is issued for either command.
  - REQ is first sampled the cycle after BUSY falls.
- Undefined: the controller enters IDLE directly after reset.

Test Plan:
- CNT_SEL=0, RW=01, MODE=0, BCD=0, COUNT=0x0004 -> writes 0x10 at A=3 then 0x04 at A=0; WR_ low 4 cycles each; 8-cycle gap; ACK in cycle 23.
- CNT_SEL=2, RW=11, MODE=3, COUNT=0x1234 -> writes 0xB6, 0x34, 0x12 in that order; ACK in cycle 38; BUSY high cycles 1..38.
- CNT_SEL=1, RW=00 -> single write of 0x40 at A=3; ACK in cycle 8.
- CNT_SEL=3 -> ERR pulse in the cycle after sampling; CS_ stays 1; BUSY stays 0.
- RESET_ low during STROBE of an LSB write -> CS_=1, WR_=1, D_OE=0 next cycle; no ACK; a new REQ after reset runs normally.
- With PC_INIT_EN defined -> after reset the bus shows 0x36, 0x00, 0x00, then 0x54, 0x12; BUSY falls after the last hold; a REQ held throughout is accepted only after that.
